ay8_mem_nop_system: RTL and testbench

- Minimal AY8 memory subsystem: one 256x8 byte memory (`Memory`) and one bus master that only fetches instructions (`NopMachine`).
- The two share a single 8-bit bidirectional address/data bus (`uniBus`) plus control lines, bundled in the `IMemory` interface.
- The master fetches bytes sequentially from address 0 and treats every opcode as NOP. The block is the bring-up vehicle for the bus protocol before the real CPU core exists.

---
 rtl/ay8_bus_pkg.sv | 27 ++
 rtl/ay8_mem_nop_system_if.sv | 74 +++++++
 rtl/ay8_mem_nop_system_memory.sv | 44 ++++
 rtl/ay8_mem_nop_system_nop.sv | 86 ++++++++
 rtl/ay8_mem_nop_system.sv | 36 +++
 tb/tb_ay8_mem_nop_system.sv | 221 ++++++++++++++++++++++
 6 files changed

// File: rtl/ay8_bus_pkg.sv
// Shared definitions for the AY8 memory/NOP-machine subsystem: bus widths,
// master state encoding and read/write polarity of the rd line.
// NOP_HALT_OPCODE_EN adds the halt opcode constant used by NopMachine.
package ay8_bus_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 2 ** ADDR_W;

    localparam logic RD = 1'b1;
    localparam logic WR = 1'b0;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        HALT
    } master_state_t;

`ifdef NOP_HALT_OPCODE_EN
    localparam data_t HALT_OPCODE = 8'hFF;
`endif

endpackage

// File: rtl/ay8_mem_nop_system_if.sv
// IMemory: bundle of the shared address/data bus and its control lines.
// Each agent publishes a data value plus an output enable; the resolved
// enable/data pair is turned into the real tri-state uniBus by the top.
// The exec* tasks form a bench-side master that only touches the ext_* lines.
interface IMemory
    import ay8_bus_pkg::*;
(
    input logic             CLK,
    input logic             RST,
    input wire [DATA_W-1:0] uniBus
);

    // NopMachine side
    logic  nm_req;
    logic  nm_rd;
    logic  nm_oe;
    data_t nm_dout;
    logic  isRunning;

    // Memory read driver
    logic  mem_oe;
    data_t mem_dout;

    // Bench-side master, written only through the exec* tasks
    logic  ext_req;
    logic  ext_rd;
    logic  ext_oe;
    data_t ext_dout;

    // Resolved bus control seen by every agent
    logic  req;
    logic  rd;
    logic  bus_oe;
    data_t bus_dout;

    assign req      = nm_req | ext_req;
    assign rd       = ext_req ? ext_rd : nm_rd;
    // Reset releases every driver at once, even in the middle of a cycle.
    assign bus_oe   = RST & req & (mem_oe | nm_oe | ext_oe);
    assign bus_dout = mem_oe ? mem_dout : (nm_oe ? nm_dout : ext_dout);

    // Start a bus cycle: ADDR phase with the given direction and address.
    task automatic exec(input logic isRead, input addr_t addr);
        ext_req  = 1'b1;
        ext_rd   = isRead;
        ext_oe   = 1'b1;
        ext_dout = addr;
    endtask

    // Enter the DATA phase: drive write data, or release the bus for a read.
    task automatic exec_data(input data_t wdata);
        ext_oe   = (ext_rd == WR);
        ext_dout = wdata;
    endtask

    // Give the bus back; the NopMachine may leave IDLE afterwards.
    task automatic exec_end();
        ext_req  = 1'b0;
        ext_rd   = RD;
        ext_oe   = 1'b0;
        ext_dout = '0;
    endtask

    modport mem (
        input  CLK, RST, uniBus, req, rd,
        output mem_oe, mem_dout
    );

    modport master (
        input  CLK, RST, uniBus, req,
        output nm_req, nm_rd, nm_oe, nm_dout, isRunning
    );

endinterface

// File: rtl/ay8_mem_nop_system_memory.sv
// Memory: 256x8 byte store on the shared bus. Tracks the two-phase bus
// cycle itself, latches the address in ADDR, then either drives the addressed
// byte (read) or writes the bus value (write) in DATA.
module Memory
    import ay8_bus_pkg::*;
(
    IMemory.mem bus
);

    data_t mem [DEPTH];
    addr_t addr_q;
    logic  rd_q;
    logic  data_phase_q;

    // Write port: store bus data at the close of a write DATA phase.
    // NOTE: the storage array has no reset; contents survive RST and a reset
    // loop over 256 entries would only cost logic for no functional benefit.
    always_ff @(posedge bus.CLK) begin
        if (data_phase_q && (rd_q == WR) && bus.req) begin
            mem[addr_q] <= bus.uniBus;
        end
    end

    // Phase tracker: capture address/direction in ADDR, then spend one DATA cycle.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge bus.CLK or negedge bus.RST) begin
        if (!bus.RST) begin
            addr_q       <= '0;
            rd_q         <= RD;
            data_phase_q <= 1'b0;
        end else if (data_phase_q) begin
            data_phase_q <= 1'b0;
        end else if (bus.req) begin
            addr_q       <= bus.uniBus;
            rd_q         <= bus.rd;
            data_phase_q <= 1'b1;
        end
    end

    assign bus.mem_oe   = data_phase_q & (rd_q == RD) & bus.req;
    assign bus.mem_dout = mem[addr_q];

endmodule

// File: rtl/ay8_mem_nop_system_nop.sv
// NopMachine: sequential instruction fetcher that treats every opcode as NOP.
// One fetch every two clocks (ADDR, DATA); pc wraps modulo 256.
// With NOP_HALT_OPCODE_EN defined, fetching 0xFF parks the master in HALT
// until reset.
module NopMachine
    import ay8_bus_pkg::*;
(
    IMemory.master      bus,
    output addr_t       pc_o,
    output data_t       ir_o,
    output logic        fetch_valid_o
);

    master_state_t state_q;
    addr_t         pc_q;
    data_t         ir_q;
    logic          fetch_valid_q;
    logic          running_q;
    logic          req_q;
    logic          addr_oe_q;

    // Fetch FSM with registered bus controls and status outputs.
    always_ff @(posedge bus.CLK or negedge bus.RST) begin
        if (!bus.RST) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            ir_q          <= '0;
            fetch_valid_q <= 1'b0;
            running_q     <= 1'b0;
            req_q         <= 1'b0;
            addr_oe_q     <= 1'b0;
        end else begin
            fetch_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Wait while a bench master holds the bus.
                    if (!bus.req) begin
                        state_q   <= ADDR;
                        running_q <= 1'b1;
                        req_q     <= 1'b1;
                        addr_oe_q <= 1'b1;
                    end
                end
                ADDR: begin
                    state_q   <= DATA;
                    addr_oe_q <= 1'b0;
                end
                DATA: begin
                    ir_q          <= bus.uniBus;
                    fetch_valid_q <= 1'b1;
                    pc_q          <= pc_q + addr_t'(1);
`ifdef NOP_HALT_OPCODE_EN
                    if (bus.uniBus == HALT_OPCODE) begin
                        state_q   <= HALT;
                        running_q <= 1'b0;
                        req_q     <= 1'b0;
                    end else begin
                        state_q   <= ADDR;
                        addr_oe_q <= 1'b1;
                    end
`else
                    state_q   <= ADDR;
                    addr_oe_q <= 1'b1;
`endif
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.nm_req    = req_q;
    assign bus.nm_rd     = RD;
    assign bus.nm_oe     = addr_oe_q;
    assign bus.nm_dout   = pc_q;
    assign bus.isRunning = running_q;

    assign pc_o          = pc_q;
    assign ir_o          = ir_q;
    assign fetch_valid_o = fetch_valid_q;

endmodule

// File: rtl/ay8_mem_nop_system.sv
// ay8_mem_nop_system: Memory and NopMachine sharing one 8-bit address/data
// bus through IMemory. The only logic here is the tri-state bus driver.
// Optional HALT-on-0xFF behaviour is enabled by NOP_HALT_OPCODE_EN.
module ay8_mem_nop_system
    import ay8_bus_pkg::*;
(
    input  logic              CLK,
    input  logic              RST,
    inout  wire  [DATA_W-1:0] uniBus,
    output logic              is_running,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic              fetch_valid
);

    IMemory u_bus (
        .CLK    (CLK),
        .RST    (RST),
        .uniBus (uniBus)
    );

    Memory memory (
        .bus (u_bus.mem)
    );

    NopMachine u_nop (
        .bus           (u_bus.master),
        .pc_o          (pc),
        .ir_o          (ir),
        .fetch_valid_o (fetch_valid)
    );

    assign is_running = u_bus.isRunning;
    assign uniBus     = u_bus.bus_oe ? u_bus.bus_dout : 'z;

endmodule

// File: tb/tb_ay8_mem_nop_system.sv
// Self-checking bench for ay8_mem_nop_system: table-driven bring-up fetches,
// a randomized 258-fetch run against an array model, reset in mid cycle,
// bench-master write/read through exec, and the 0xFF opcode behaviour.
`timescale 1ns/1ps
module tb_ay8_mem_nop_system;
    import ay8_bus_pkg::*;

    logic       CLK = 1'b0;
    logic       RST;
    wire  [7:0] bus_w;
    logic       is_running;
    logic [7:0] pc;
    logic [7:0] ir;
    logic       fetch_valid;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] model_mem [256];

    typedef struct {
        int         addr;
        logic [7:0] mem_val;
        logic [7:0] exp_ir;
        logic [7:0] exp_pc;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [4];

    always #5 CLK = ~CLK;

    ay8_mem_nop_system dut (
        .CLK         (CLK),
        .RST         (RST),
        .uniBus      (bus_w),
        .is_running  (is_running),
        .pc          (pc),
        .ir          (ir),
        .fetch_valid (fetch_valid)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic preload(input int a, input logic [7:0] v);
        dut.memory.mem[a] <= v;
        model_mem[a] = v;
    endtask

    // Advance negedge by negedge until fetch_valid is seen, bounded.
    task automatic wait_fetch(output int cycles);
        cycles = 0;
        do begin
            @(negedge CLK);
            cycles++;
        end while (fetch_valid !== 1'b1 && cycles < 20);
        check("fetch_seen", fetch_valid, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int pc_m;
        logic [7:0] v;

        vecs[0] = '{0, 8'h10, 8'h10, 8'h01, 2};
        vecs[1] = '{1, 8'h11, 8'h11, 8'h02, 2};
        vecs[2] = '{2, 8'h12, 8'h12, 8'h03, 2};
        vecs[3] = '{3, 8'h13, 8'h13, 8'h04, 2};

        // ---------------- reset and table-driven bring-up ----------------
        RST = 1'b1;
        dut.u_bus.exec_end();
        #1 RST = 1'b0;
        for (int i = 0; i < 256; i++) preload(i, 8'h00);
        for (int i = 0; i < 4; i++) preload(vecs[i].addr, vecs[i].mem_val);
        #1;
        check("rst_running", is_running, 0);
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_fv", fetch_valid, 0);
        check("rst_req", dut.u_bus.req, 0);
        check("rst_bus_oe", dut.u_bus.bus_oe, 0);
        @(negedge CLK);  // t=10, one posedge spent in reset
        check("rst_hold_running", is_running, 0);
        check("rst_hold_pc", pc, 0);
        @(negedge CLK);
        RST = 1'b1;      // t=20
        @(negedge CLK);  // first edge after release has passed
        check("start_running", is_running, 1);
        check("start_req", dut.u_bus.req, 1);
        check("start_addr_on_bus", bus_w, 8'h00);
        check("start_fv", fetch_valid, 0);
        for (int i = 0; i < 4; i++) begin
            wait_fetch(cyc);
            check($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
            check($sformatf("vec%0d_ir", i), ir, vecs[i].exp_ir);
            check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
            check($sformatf("vec%0d_next_addr", i), bus_w, vecs[i].exp_pc);
        end

        // ---------------- randomized run with pc wrap ----------------
        @(negedge CLK);
        RST = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom_range(0, 255));
`ifdef NOP_HALT_OPCODE_EN
            if (v == 8'hFF) v = 8'hFE;
`endif
            preload(i, v);
        end
        preload(0, 8'h10);
        @(negedge CLK);
        RST = 1'b1;
        pc_m = 0;
        for (int k = 0; k < 258; k++) begin
            wait_fetch(cyc);
            check("rnd_cycles", cyc, (k == 0) ? 3 : 2);
            check("rnd_ir", ir, model_mem[pc_m]);
            pc_m = (pc_m + 1) % 256;
            check("rnd_pc", pc, pc_m);
            if (k == 255) check("wrap_pc", pc, 8'h00);
            if (k == 256) check("wrap_ir", ir, 8'h10);
        end

        // ---------------- reset during a DATA phase ----------------
        @(negedge CLK);
        check("data_phase_oe", dut.u_bus.bus_oe, 1);
        check("data_phase_bus", bus_w, model_mem[pc_m]);
        RST = 1'b0;
        #1;
        check("midrst_bus_oe", dut.u_bus.bus_oe, 0);
        check("midrst_pc", pc, 0);
        check("midrst_ir", ir, 0);
        check("midrst_running", is_running, 0);
        check("midrst_req", dut.u_bus.req, 0);
        @(negedge CLK);
        RST = 1'b1;
        wait_fetch(cyc);
        check("restart_cycles", cyc, 3);
        check("restart_ir", ir, model_mem[0]);
        check("restart_pc", pc, 1);

        // ---------------- bench master write/read via exec ----------------
        @(negedge CLK);
        RST = 1'b0;
        dut.u_bus.exec(WR, 8'hFF);
        @(negedge CLK);
        RST = 1'b1;
        #1;
        check("exec_wr_addr_bus", bus_w, 8'hFF);
        @(negedge CLK);
        check("exec_held_idle", is_running, 0);
        dut.u_bus.exec_data(8'hAA);
        @(negedge CLK);
        model_mem[255] = 8'hAA;
        dut.u_bus.exec(RD, 8'hFF);
        @(negedge CLK);
        dut.u_bus.exec_data(8'h00);
        #1;
        check("exec_rd_oe", dut.u_bus.bus_oe, 1);
        check("exec_rd_data", bus_w, 8'hAA);
        check("exec_pc_idle", pc, 0);
        @(negedge CLK);
        dut.u_bus.exec_end();
        #1;
        check("exec_end_oe", dut.u_bus.bus_oe, 0);
        wait_fetch(cyc);
        check("post_exec_cycles", cyc, 3);
        check("post_exec_ir", ir, model_mem[0]);

        // ---------------- 0xFF opcode ----------------
        @(negedge CLK);
        RST = 1'b0;
        preload(0, 8'h10);
        preload(1, 8'h11);
        preload(2, 8'hFF);
        preload(3, 8'h13);
        @(negedge CLK);
        RST = 1'b1;
        wait_fetch(cyc);
        check("ff_ir0", ir, 8'h10);
        wait_fetch(cyc);
        check("ff_ir1", ir, 8'h11);
        wait_fetch(cyc);
        check("ff_ir2", ir, 8'hFF);
        check("ff_pc2", pc, 3);
`ifdef NOP_HALT_OPCODE_EN
        check("halt_running", is_running, 0);
        check("halt_req", dut.u_bus.req, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            check("halt_fv", fetch_valid, 0);
            check("halt_req_hold", dut.u_bus.req, 0);
            check("halt_bus_oe", dut.u_bus.bus_oe, 0);
            check("halt_pc", pc, 3);
        end
`else
        check("nop_running", is_running, 1);
        wait_fetch(cyc);
        check("nop_cycles", cyc, 2);
        check("nop_ir3", ir, 8'h13);
        check("nop_pc3", pc, 4);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
